core_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32 core datapath.
//  - Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  - Drives the imem/dmem req/ack handshakes, IR latch, PC update and gated regfile write.
//  - Sits between the opcode decoder (which supplies opcode_i/RWR_EN) and the PC/IR/memories.
//  - Keeps retired-instruction and active-cycle counters.

---
 rtl/core_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle sequencer for the RV32 core datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the imem/dmem
// request/ack handshakes, the IR latch, the PC update and a gated regfile write.
// It also keeps retired-instruction and active-cycle counters.
//
// Handshake semantics: a request output stays high for every cycle the FSM waits
// in FETCH (imem) or MEM (dmem). The memory answers with a single-cycle ack pulse,
// and the transfer completes on the clock edge where that ack is sampled high.
// An ack that arrives while no request is up is dropped.
//
// Optional feature: define CORE_SEQ_TIMEOUT_EN to bound ack waits to
// TIMEOUT_CYCLES cycles. When a wait runs out, the core enters HALT and raises a
// sticky err_o. Without the macro the core waits indefinitely and err_o is 0.
module core_seq_ctrl #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [6:0]       opcode_i,
    input  logic             rwr_en_i,
    input  logic             imem_ack_i,
    input  logic             dmem_ack_i,
    output logic             imem_req_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic             IR_EN_o,
    output logic             PC_EN_o,
    output logic             RWR_EN_o,
    output logic [2:0]       state_o,
    output logic             halted_o,
    output logic             err_o,
    output logic [CNT_W-1:0] instret_o,
    output logic [CNT_W-1:0] cycle_o
);

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] cycle_q;

    logic is_store;
    logic is_mem;
    logic wb_blocked;
    logic wait_expired;

    // A zero-cycle timeout would be meaningless; this block exists only to flag that configuration.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_invalid
    end

    assign is_store   = (opcode_i == OP_STORE);
    assign is_mem     = (opcode_i == OP_LOAD) || is_store;
    // Stores and branches never produce a register result.
    assign wb_blocked = is_store || (opcode_i == OP_BRANCH);

`ifdef CORE_SEQ_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;
    logic              err_q;

    // A waiting cycle is one spent in FETCH or MEM with no ack sampled.
    assign waiting      = ((state == S_FETCH) && !imem_ack_i) || ((state == S_MEM) && !dmem_ack_i);
    // The limit is reached on the last allowed waiting cycle. An ack on that same cycle still wins.
    assign wait_expired = waiting && (wait_cnt == WAIT_LAST);

    // Count consecutive waiting cycles. Any other cycle clears the count, so it is fresh on each FETCH/MEM entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (waiting) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (wait_expired) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign wait_expired = 1'b0;
    assign err_o        = 1'b0;
`endif

    // Sequencer FSM plus retire/active-cycle counters. Acks are ignored while reset is held.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            instret_q <= '0;
            cycle_q   <= '0;
        end else begin
            if ((state != S_IDLE) && (state != S_HALT)) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (run_i) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack_i)        state <= S_DECODE;
                    else if (wait_expired) state <= S_HALT;
                end
                S_DECODE: begin
                    state <= (opcode_i == OP_SYSTEM) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    state <= is_mem ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (dmem_ack_i)        state <= S_WB;
                    else if (wait_expired) state <= S_HALT;
                end
                S_WB: begin
                    instret_q <= instret_q + CNT_W'(1);
                    state     <= run_i ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are decoded from the registered state. IR_EN also needs the fetch ack,
    // and RWR_EN also needs the decoder's write request.
    assign imem_req_o = (state == S_FETCH);
    assign dmem_req_o = (state == S_MEM);
    assign dmem_we_o  = (state == S_MEM) && is_store;
    assign IR_EN_o    = (state == S_FETCH) && imem_ack_i && !rst_i;
    assign PC_EN_o    = (state == S_WB);
    assign RWR_EN_o   = (state == S_WB) && rwr_en_i && !wb_blocked;
    assign halted_o   = (state == S_HALT);
    assign state_o    = state;
    assign instret_o  = instret_q;
    assign cycle_o    = cycle_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: scoreboard bench for core_seq_ctrl.
// A driver issues instructions and pushes the expected retire and dmem results.
// A negedge monitor pops and compares them whenever the DUT retires or completes a dmem transfer.
module tb_core_seq_ctrl;

  localparam int CNT_W = 32;
  localparam int W     = 2 * CNT_W + 1;

  localparam logic [6:0] OP_ADD    = 7'h33;
  localparam logic [6:0] OP_ADDI   = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_ECALL  = 7'h73;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i, run_i, rwr_en_i, imem_ack_i, dmem_ack_i;
  logic [6:0]       opcode_i;
  logic             imem_req_o, dmem_req_o, dmem_we_o, IR_EN_o, PC_EN_o, RWR_EN_o;
  logic [2:0]       state_o;
  logic             halted_o, err_o;
  logic [CNT_W-1:0] instret_o, cycle_o;

  core_seq_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .opcode_i(opcode_i), .rwr_en_i(rwr_en_i),
    .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i), .imem_req_o(imem_req_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .IR_EN_o(IR_EN_o), .PC_EN_o(PC_EN_o),
    .RWR_EN_o(RWR_EN_o), .state_o(state_o), .halted_o(halted_o), .err_o(err_o),
    .instret_o(instret_o), .cycle_o(cycle_o)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [W-1:0]     exp_q[$];      // {rwr_en, instret, cycle_o} seen during WB
  logic             exp_mem_q[$];  // expected dmem_we per dmem transfer
  logic [8:0]       trace_q[$];
  logic [8:0]       exp_tr[$];
  bit               trace_on = 1'b0;
  logic [CNT_W-1:0] model_instret;
  logic [CNT_W-1:0] model_cycles;
  logic [W-1:0]     mon_e;
  logic [6:0]       ops[6] = '{OP_ADD, OP_ADDI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
  logic [6:0]       r_op;
  int               r_wait;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input logic [127:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return imem_req_o;
      1:       return dmem_req_o;
      2:       return PC_EN_o;
      default: return halted_o;
    endcase
  endfunction

  // Bounded wait for a DUT output; expiry counts as a failed comparison.
  task automatic wait_sig(input string name, input int which, input int max_cycles);
    int n;
    n = 0;
    while (!sig(which) && n < max_cycles) begin
      step();
      n++;
    end
    if (!sig(which)) report_fail(name, 128'(n));
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    run_i      = 1'b0;
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
    rwr_en_i   = 1'b0;
    exp_q.delete();
    exp_mem_q.delete();
    model_instret = '0;
    model_cycles  = '0;
    repeat (2) step();
    rst_i = 1'b0;
  endtask

  // Issue one instruction. The imem ack comes after idly waiting cycles and the dmem ack after ddly.
  // Reference model: each instruction costs (idly+1) fetch + decode + exec + optional (ddly+1) mem + wb.
  task automatic do_instr(input logic [6:0] op, input int idly, input int ddly,
                          input logic rwr, input logic run_after);
    logic mem;
    int   lat;
    mem = (op == OP_LOAD) || (op == OP_STORE);
    lat = (idly + 1) + 2 + (mem ? ddly + 1 : 0) + 1;
    if (op == OP_ECALL) begin
      model_cycles = model_cycles + CNT_W'(idly + 2);
    end else begin
      exp_q.push_back({rwr && op != OP_STORE && op != OP_BRANCH, model_instret,
                       model_cycles + CNT_W'(lat - 1)});
      if (mem) exp_mem_q.push_back(op == OP_STORE);
      model_instret = model_instret + 1;
      model_cycles  = model_cycles + CNT_W'(lat);
    end
    opcode_i = op;
    rwr_en_i = rwr;
    run_i    = 1'b1;
    wait_sig("wait_imem_req", 0, 40);
    repeat (idly) step();
    imem_ack_i = 1'b1;
    step();
    imem_ack_i = 1'b0;
    run_i      = run_after;
    if (op == OP_ECALL) begin
      chk("ecall_decode", 128'(state_o), 128'(2));
      step();
      chk("ecall_halt_next", 128'(state_o), 128'(6));
      return;
    end
    if (mem) begin
      wait_sig("wait_dmem_req", 1, 5);
      repeat (ddly) step();
      dmem_ack_i = 1'b1;
      step();
      dmem_ack_i = 1'b0;
    end
    wait_sig("wait_wb", 2, 5);
    step();
  endtask

  task automatic compare_trace(input string name);
    chk(name, 128'(trace_q.size()), 128'(exp_tr.size()));
    for (int i = 0; i < exp_tr.size() && i < trace_q.size(); i++) chk(name, 128'(trace_q[i]), 128'(exp_tr[i]));
    trace_q.delete();
    exp_tr.delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_i) begin
      if (trace_on && state_o != 3'd0)
        trace_q.push_back({IR_EN_o, PC_EN_o, RWR_EN_o, dmem_req_o, dmem_we_o, imem_req_o, state_o});
      if (PC_EN_o) begin
        if (exp_q.size() == 0) begin
          report_fail("retire_unexpected", 128'({RWR_EN_o, instret_o, cycle_o}));
        end else begin
          mon_e = exp_q.pop_front();
          chk("retire", 128'({RWR_EN_o, instret_o, cycle_o}), 128'(mon_e));
        end
      end
      if (dmem_req_o && dmem_ack_i) begin
        if (exp_mem_q.size() == 0) report_fail("dmem_unexpected", 128'(dmem_we_o));
        else chk("dmem_we", 128'(dmem_we_o), 128'(exp_mem_q.pop_front()));
      end
      if (imem_req_o && dmem_req_o) report_fail("both_reqs", 128'(state_o));
      if (halted_o) chk("halt_quiet", 128'({imem_req_o, dmem_req_o, PC_EN_o, RWR_EN_o, IR_EN_o}), 128'(0));
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_i = 1'b1; run_i = 1'b0; opcode_i = OP_ADD; rwr_en_i = 1'b0;
    imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
    step();
    do_reset();
    chk("reset_state", 128'(state_o), 128'(0));
    chk("reset_strobes", 128'({imem_req_o, dmem_req_o, dmem_we_o, IR_EN_o, PC_EN_o, RWR_EN_o, halted_o, err_o}), 128'(0));
    chk("reset_counters", 128'({instret_o, cycle_o}), 128'(0));

    // ADD, immediate ack: FETCH, DECODE, EXEC, WB, then back to FETCH
    trace_on = 1'b1;
    exp_tr.push_back(9'b1_0_0_0_0_1_001);
    exp_tr.push_back(9'b0_0_0_0_0_0_010);
    exp_tr.push_back(9'b0_0_0_0_0_0_011);
    exp_tr.push_back(9'b0_1_1_0_0_0_101);
    do_instr(OP_ADD, 0, 0, 1'b1, 1'b1);
    trace_on = 1'b0;
    compare_trace("add_trace");
    chk("add_refetch", 128'(state_o), 128'(1));
    chk("add_instret", 128'(instret_o), 128'(1));

    // LOAD with dmem ack 3 cycles after MEM entry
    do_reset();
    trace_on = 1'b1;
    exp_tr.push_back(9'b1_0_0_0_0_1_001);
    exp_tr.push_back(9'b0_0_0_0_0_0_010);
    exp_tr.push_back(9'b0_0_0_0_0_0_011);
    repeat (4) exp_tr.push_back(9'b0_0_0_1_0_0_100);
    exp_tr.push_back(9'b0_1_1_0_0_0_101);
    do_instr(OP_LOAD, 0, 3, 1'b1, 1'b0);
    trace_on = 1'b0;
    compare_trace("load_trace");
    chk("load_cycle", 128'(cycle_o), 128'(8));
    chk("load_idle", 128'(state_o), 128'(0));

    // STORE with a write request from the decoder: the write must be gated off
    do_instr(OP_STORE, 1, 1, 1'b1, 1'b0);
    chk("store_instret", 128'(instret_o), 128'(model_instret));

    // stray acks while idle
    imem_ack_i = 1'b1;
    dmem_ack_i = 1'b1;
    step();
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
    chk("stray_ack_idle", 128'({state_o, instret_o}), 128'({3'd0, model_instret}));

    // randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      r_op = ops[$urandom_range(0, 5)];
      do_instr(r_op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               (i == 59) ? 1'b0 : 1'($urandom_range(0, 1)));
    end
    chk("queues_drained", 128'(exp_q.size() + exp_mem_q.size()), 128'(0));
    chk("rand_cycle", 128'(cycle_o), 128'(model_cycles));
    chk("rand_instret", 128'(instret_o), 128'(model_instret));

    // ECALL halts and stays halted with run_i high
    do_reset();
    do_instr(OP_ECALL, 0, 0, 1'b0, 1'b1);
    chk("ecall_halted", 128'(halted_o), 128'(1));
    chk("ecall_cycle", 128'(cycle_o), 128'(model_cycles));
    repeat (20) step();
    chk("halt_sticky", 128'({state_o, halted_o}), 128'({3'd6, 1'b1}));
    chk("halt_counters", 128'({instret_o, cycle_o}), 128'({CNT_W'(0), model_cycles}));
    do_reset();
    chk("halt_reset", 128'({state_o, halted_o}), 128'(0));

    // reset during a MEM wait abandons the transfer
    opcode_i = OP_LOAD;
    run_i    = 1'b1;
    wait_sig("t5_imem_req", 0, 10);
    imem_ack_i = 1'b1;
    step();
    imem_ack_i = 1'b0;
    wait_sig("t5_dmem_req", 1, 5);
    step();
    rst_i      = 1'b1;
    dmem_ack_i = 1'b1;
    step();
    rst_i      = 1'b0;
    dmem_ack_i = 1'b0;
    run_i      = 1'b0;
    chk("mem_reset", 128'({state_o, dmem_req_o, instret_o}), 128'(0));
    step();
    dmem_ack_i = 1'b1;
    step();
    dmem_ack_i = 1'b0;
    chk("late_dmem_ack", 128'({state_o, dmem_req_o, PC_EN_o}), 128'(0));

    // imem never acks
    do_reset();
    opcode_i = OP_ADD;
    run_i    = 1'b1;
    wait_sig("to_imem_req", 0, 10);
`ifdef CORE_SEQ_TIMEOUT_EN
    r_wait = 1;
    while (imem_req_o && r_wait < 20) begin
      step();
      if (imem_req_o) r_wait++;
    end
    chk("timeout_wait_cycles", 128'(r_wait), 128'(4));
    chk("timeout_halt", 128'({state_o, err_o}), 128'({3'd6, 1'b1}));
    repeat (3) step();
    chk("timeout_err_sticky", 128'(err_o), 128'(1));
    do_reset();
    chk("timeout_err_cleared", 128'(err_o), 128'(0));
    run_i = 1'b1;
    wait_sig("to_imem_req2", 0, 10);
    repeat (3) step();
    imem_ack_i = 1'b1;
    step();
    imem_ack_i = 1'b0;
    chk("ack_on_limit", 128'({state_o, err_o}), 128'({3'd2, 1'b0}));
`else
    r_wait = $urandom_range(20, 30);
    repeat (r_wait) step();
    chk("no_timeout_wait", 128'({state_o, halted_o, err_o}), 128'({3'd1, 1'b0, 1'b0}));
`endif
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
